// File: rtl/lut_bank_cfg.sv
// lut_bank_cfg: bank of LANES runtime-programmable K-input LUTs with a streamed config loader.
//   Ports: i_clk, i_rst_n (async, active-low)
//          i_cfg_start/i_cfg_valid/i_cfg_data -> o_cfg_ready/o_cfg_done/o_cfg_busy (loader)
//          i_in (LANES*K) -> o_out (LANES), o_out_valid (evaluation, gated by ARMED)
//          i_rd_en/i_rd_addr -> o_rd_data/o_rd_valid (mask readback)
//   Optional feature macro: LUT_BANK_READBACK_EN enables readback; otherwise o_rd_* are tied to 0.
module lut_bank_cfg #(
    parameter int K     = 6,
    parameter int LANES = 4,
    parameter int CFG_W = 8,
    localparam int M    = 1 << K,
    localparam int WPL  = M / CFG_W,
    localparam int NW   = LANES * WPL,
    localparam int AW   = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_start,
    input  logic                 i_cfg_valid,
    input  logic [CFG_W-1:0]     i_cfg_data,
    output logic                 o_cfg_ready,
    output logic                 o_cfg_done,
    output logic                 o_cfg_busy,
    input  logic [LANES*K-1:0]   i_in,
    output logic [LANES-1:0]     o_out,
    output logic                 o_out_valid,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [CFG_W-1:0]     o_rd_data,
    output logic                 o_rd_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wp;
    logic            r_done;
    logic [M-1:0]    r_mask [LANES];
    logic            w_acc;
    logic            w_last;
    // A restart in the same cycle as a valid word wins; the word is dropped.
    assign w_acc  = i_cfg_valid && (r_state == LOAD) && !i_cfg_start;
    assign w_last = r_wp == AW'(NW - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = i_cfg_start ? LOAD : (w_acc && w_last) ? ARMED : r_state;
    end
    always_comb begin
        o_cfg_ready = r_state == LOAD;
        o_cfg_busy  = r_state == LOAD;
        o_out_valid = r_state == ARMED;
        o_cfg_done  = r_done;
        for (int l = 0; l < LANES; l++)
            o_out[l] = (r_state == ARMED) && r_mask[l][i_in[l*K +: K]];
    end
    // Word wp lands in lane wp/WPL at bit offset (wp%WPL)*CFG_W; mask bits persist until overwritten.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp   <= '0;
            r_done <= 1'b0;
            for (int l = 0; l < LANES; l++) r_mask[l] <= '0;
        end else begin
            r_done <= w_acc && w_last;
            if (i_cfg_start)
                r_wp <= '0;
            else if (w_acc)
                r_wp <= w_last ? '0 : r_wp + 1'b1;
            if (w_acc)
                for (int l = 0; l < LANES; l++)
                    for (int w = 0; w < WPL; w++)
                        if (r_wp == AW'(l*WPL + w)) r_mask[l][w*CFG_W +: CFG_W] <= i_cfg_data;
        end
    end
`ifdef LUT_BANK_READBACK_EN
    logic               w_rd_ok;
    logic [CFG_W-1:0]   w_rd_word;
    logic [CFG_W-1:0]   r_rd_data;
    logic               r_rd_valid;
    assign w_rd_ok = i_rd_en && (r_state != LOAD) && (32'(i_rd_addr) < NW);
    always_comb begin
        w_rd_word = '0;
        for (int l = 0; l < LANES; l++)
            for (int w = 0; w < WPL; w++)
                if (i_rd_addr == AW'(l*WPL + w)) w_rd_word = r_mask[l][w*CFG_W +: CFG_W];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) r_rd_data <= w_rd_word;
        end
    end
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{i_rd_en, i_rd_addr};
    assign o_rd_data   = '0;
    assign o_rd_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_lut_bank_cfg.sv
// tb_lut_bank_cfg: directed self-checking bench for lut_bank_cfg (K=6, LANES=4, CFG_W=8).
module tb_lut_bank_cfg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready, cfg_done, cfg_busy;
    logic [23:0] in;
    logic [3:0]  out;
    logic        out_valid;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  wds [32];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lut_bank_cfg dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_start(cfg_start), .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
        .o_cfg_ready(cfg_ready), .o_cfg_done(cfg_done), .o_cfg_busy(cfg_busy),
        .i_in(in), .o_out(out), .o_out_valid(out_valid),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic v);
        cfg_start = 1'b1;
        cfg_valid = v;
        cfg_data  = 8'h00;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        #1;
    endtask

    // Streams n words from wds; for a full load also checks the done pulse timing.
    task automatic load_words(input int n, input bit stall);
        int acc   = 0;
        int cyc   = 0;
        int dones = 0;
        while (acc < n && cyc < 400) begin
            cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data  = wds[acc];
            #1;
            if (cfg_done) dones++;
            if (cfg_valid && cfg_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("load_accepted", acc, n);
        if (n == 32) begin
            #1;
            check("done_pulse", {31'd0, cfg_done}, 1);
            check("ready_after_load", {31'd0, cfg_ready}, 0);
            check("busy_after_load", {31'd0, cfg_busy}, 0);
            check("out_valid_after_load", {31'd0, out_valid}, 1);
            check("early_done_pulses", dones, 0);
            @(negedge clk);
            #1;
            check("done_one_cycle", {31'd0, cfg_done}, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        in = '1; rd_en = 1'b0; rd_addr = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out", {28'd0, out}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_ready", {31'd0, cfg_ready}, 0);
        check("rst_busy", {31'd0, cfg_busy}, 0);
        check("rst_done", {31'd0, cfg_done}, 0);
        check("rst_rd_data", {24'd0, rd_data}, 0);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);

        // Stall load: all FF except word 9 (lane 1, bits 8..15) = 01.
        for (int i = 0; i < 32; i++) wds[i] = 8'hFF;
        wds[9] = 8'h01;
        @(negedge clk);
        do_start(1'b0);
        check("ready_after_start", {31'd0, cfg_ready}, 1);
        check("busy_after_start", {31'd0, cfg_busy}, 1);
        load_words(32, 1'b1);
        in = {6'd0, 6'd0, 6'd8, 6'd0};
        #1 check("eval_l1_in8", {28'd0, out}, 4'b1111);
        in = {6'd63, 6'd63, 6'd9, 6'd63};
        #1 check("eval_l1_in9", {28'd0, out}, 4'b1101);
        in = {6'd5, 6'd40, 6'd15, 6'd17};
        #1 check("eval_mix", {28'd0, out}, 4'b1101);

        // Restart from ARMED, partial load, restart with a colliding word, then full A5 load.
        for (int i = 0; i < 32; i++) wds[i] = 8'hA5;
        in = {6'd0, 6'd0, 6'd8, 6'd0};
        @(negedge clk);
        do_start(1'b0);
        check("rearm_out_valid", {31'd0, out_valid}, 0);
        check("rearm_out", {28'd0, out}, 0);
        load_words(10, 1'b0);
        check("partial_out_valid", {31'd0, out_valid}, 0);
        do_start(1'b1);
        check("restart_ready", {31'd0, cfg_ready}, 1);
        check("restart_out_valid", {31'd0, out_valid}, 0);
        load_words(32, 1'b0);
        in = {6'd62, 6'd7, 6'd13, 6'd3};
        #1 check("a5_eval_a", {28'd0, out}, 4'b0110);
        in = {6'd63, 6'd6, 6'd9, 6'd0};
        #1 check("a5_eval_b", {28'd0, out}, 4'b1001);

        // Readback while ARMED.
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 5'd31;
        @(negedge clk);
        rd_en = 1'b0;
        #1;
`ifdef LUT_BANK_READBACK_EN
        check("rd_valid_armed", {31'd0, rd_valid}, 1);
        check("rd_data_armed", {24'd0, rd_data}, 8'hA5);
`else
        check("rd_valid_off", {31'd0, rd_valid}, 0);
        check("rd_data_off", {24'd0, rd_data}, 0);
`endif
        @(negedge clk);
        #1 check("rd_valid_one_cycle", {31'd0, rd_valid}, 0);

        // Reload 20 words, attempt readback in LOAD, then async reset mid-load.
        for (int i = 0; i < 32; i++) wds[i] = 8'h3C;
        @(negedge clk);
        do_start(1'b0);
        load_words(20, 1'b0);
        rd_en = 1'b1; rd_addr = 5'd3;
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        check("rd_valid_in_load", {31'd0, rd_valid}, 0);
`ifdef LUT_BANK_READBACK_EN
        check("rd_data_held", {24'd0, rd_data}, 8'hA5);
`else
        check("rd_data_load_off", {24'd0, rd_data}, 0);
`endif
        in = '1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, cfg_ready}, 0);
        check("arst_busy", {31'd0, cfg_busy}, 0);
        check("arst_out", {28'd0, out}, 0);
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_rd_data", {24'd0, rd_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in = '0;
        #1;
        check("post_rst_out", {28'd0, out}, 0);
        check("post_rst_ready", {31'd0, cfg_ready}, 0);
        check("post_rst_out_valid", {31'd0, out_valid}, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("idle_ignores_valid", {31'd0, cfg_ready | out_valid | cfg_done}, 0);
`ifdef LUT_BANK_READBACK_EN
        rd_en = 1'b1; rd_addr = 5'd20;
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        check("rd_valid_idle", {31'd0, rd_valid}, 1);
        check("rd_mask_cleared", {24'd0, rd_data}, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
